// File: rtl/task_pkg.sv
// rtl/task_pkg.sv - shared opcodes, task state encodings and dispatcher FSM states
package task_pkg;

    localparam logic [3:0] OP_NOP      = 4'b0000;
    localparam logic [3:0] OP_READY    = 4'b0001;
    localparam logic [3:0] OP_SUSPEND  = 4'b0010;
    localparam logic [3:0] OP_WAIT     = 4'b0011;
    localparam logic [3:0] OP_KILL     = 4'b0100;
    localparam logic [3:0] OP_PRIO     = 4'b0101;
    localparam logic [3:0] OP_HIT      = 4'b0110;
    localparam logic [3:0] OP_EXEC     = 4'b0111;
    localparam logic [3:0] OP_KILL_ALL = 4'b1100;

    localparam logic [15:0] OP_IDLE = 16'h0000;

    typedef enum logic [1:0] {
        TS_READY      = 2'b00,
        TS_WAITING    = 2'b01,
        TS_SUSPENDED  = 2'b10,
        TS_TERMINATED = 2'b11
    } task_state_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } disp_state_e;

    function automatic logic [15:0] make_op(input logic [11:0] cmd);
        return {4'b0000, cmd};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command queue with registered storage and full/empty flags
module cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// rtl/task_dispatcher.sv - per-node op-word scheduler: queued host commands plus quantum-paced auto Execute
module task_dispatcher
    import task_pkg::*;
#(
    parameter int NUM_TASKS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int QUANTUM     = 10000,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_TASKS-1:0] task_status,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [11:0]            cmd_data,
    input  logic                   auto_en,
    output logic [15:0]            op_word,
    output logic                   busy,
    output logic [15:0]            exec_count,
    output logic [3:0]             sel_task
);
    localparam logic [31:0] Q_LAST    = 32'(QUANTUM - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    disp_state_e state;
    disp_state_e state_next;
    logic [15:0] phase;
    logic [15:0] phase_next;
    logic [15:0] op_next;
    logic [31:0] q_cnt;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        auto_launch;
    logic [11:0] head;
    logic        found;
    logic [3:0]  best_prio;
    logic [3:0]  best_id;

    cmd_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data (cmd_data),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE);

    // Strictly-greater compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        found     = 1'b0;
        best_prio = 4'h0;
        best_id   = 4'h0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (task_status[8*i +: 8] != 8'h00 &&
                (!found || task_status[8*i+4 +: 4] > best_prio)) begin
                found     = 1'b1;
                best_prio = task_status[8*i+4 +: 4];
                best_id   = task_status[8*i +: 4];
            end
        end
    end

    always_comb begin
        state_next  = state;
        op_next     = op_word;
        phase_next  = phase + 16'd1;
        fifo_pop    = 1'b0;
        auto_launch = 1'b0;
        case (state)
            ST_IDLE: begin
                op_next    = OP_IDLE;
                phase_next = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head[7:4] != OP_NOP) begin
                        op_next    = make_op(head);
                        state_next = ST_HOLD;
                    end
                end else if (auto_en && q_cnt == Q_LAST && found) begin
                    auto_launch = 1'b1;
                    op_next     = {4'b0000, best_id, OP_EXEC, 4'b0000};
                    state_next  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (phase == HOLD_LAST) begin
                    op_next    = OP_IDLE;
                    phase_next = '0;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase == GAP_LAST) begin
                    phase_next = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                op_next    = OP_IDLE;
                phase_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= '0;
            op_word    <= OP_IDLE;
            q_cnt      <= '0;
            exec_count <= '0;
            sel_task   <= '0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            op_word <= op_next;
            if (auto_launch) begin
                q_cnt <= '0;
            end else if (q_cnt != Q_LAST) begin
                q_cnt <= q_cnt + 32'd1;
            end
            if (state == ST_IDLE && state_next == ST_HOLD && op_next[7:4] == OP_EXEC) begin
                exec_count <= exec_count + 16'd1;
            end
            if (auto_launch) begin
                sel_task <= best_id;
            end
        end
    end

endmodule

// File: tb/tb_task_dispatcher.sv
// tb/tb_task_dispatcher.sv - randomized self-checking bench for task_dispatcher
module tb_task_dispatcher;
    localparam int NT = 4;
    localparam int FD = 4;
    localparam int QT = 16;
    localparam int HC = 4;
    localparam int GC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NT-1:0] task_status;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [11:0]     cmd_data;
    logic            auto_en;
    logic [15:0]     op_word;
    logic            busy;
    logic [15:0]     exec_count;
    logic [3:0]      sel_task;

    int checks   = 0;
    int errors   = 0;
    int exp_exec = 0;
    int cyc      = 0;
    logic [15:0] mon_w[$];
    int          mon_len[$];
    int          mon_gap[$];
    int          mon_start[$];

    task_dispatcher #(
        .NUM_TASKS(NT), .FIFO_DEPTH(FD), .QUANTUM(QT), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)
    ) dut (
        .clk(clk), .rst(rst), .task_status(task_status), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_data(cmd_data), .auto_en(auto_en), .op_word(op_word),
        .busy(busy), .exec_count(exec_count), .sel_task(sel_task)
    );

    always #5 clk = ~clk;

    // Op-word trace: every non-zero run is logged with its length, preceding zero run and start cycle.
    initial begin
        logic [15:0] cur;
        int run;
        int zl;
        cur = '0;
        run = 0;
        zl  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (op_word == 16'h0000) begin
                if (run > 0) begin
                    mon_w.push_back(cur);
                    mon_len.push_back(run);
                    run = 0;
                    zl  = 0;
                end
                zl++;
            end else if (run > 0 && op_word == cur) begin
                run++;
            end else begin
                if (run > 0) begin
                    mon_w.push_back(cur);
                    mon_len.push_back(run);
                    zl = 0;
                end
                cur = op_word;
                run = 1;
                mon_gap.push_back(zl);
                mon_start.push_back(cyc);
                zl = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit arb_model(input logic [8*NT-1:0] st, output logic [3:0] id);
        bit hit;
        hit = 1'b0;
        id  = 4'h0;
        for (int p = 15; p >= 0; p--) begin
            for (int i = 0; i < NT; i++) begin
                if (!hit && st[8*i +: 8] != 8'h00 && int'(st[8*i+4 +: 4]) == p) begin
                    hit = 1'b1;
                    id  = st[8*i +: 4];
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [8*NT-1:0] rand_status();
        logic [8*NT-1:0] s;
        s = '0;
        for (int i = 0; i < NT; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                s[8*i +: 8] = {4'($urandom_range(2, 5)), 4'($urandom_range(0, 15))};
            end
        end
        return s;
    endfunction

    function automatic logic [11:0] rand_cmd(input bit allow_nop);
        logic [3:0] opc;
        int r;
        r = $urandom_range(0, 3);
        if (r == 0)      opc = allow_nop ? 4'h0 : 4'h7;
        else if (r == 1) opc = 4'h7;
        else             opc = 4'($urandom_range(1, 15));
        return {4'($urandom_range(0, 15)), opc, 4'($urandom_range(0, 15))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [11:0] c, output bit ok);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = c;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        ok = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_op(input int limit, output bit ok);
        int n;
        n = 0;
        while (op_word == 16'h0000 && n < limit) begin
            tick();
            n++;
        end
        ok = (op_word != 16'h0000);
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n;
        n = 0;
        while ((busy || op_word != 16'h0000) && n < limit) begin
            tick();
            n++;
        end
        ok = !busy && op_word == 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; auto_en = 1'b0; task_status = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (op_word !== 16'h0000) begin errors++; $display("FAIL reset_op got %h want 0000", op_word); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (exec_count !== 16'h0000) begin errors++; $display("FAIL reset_exec got %0d want 0", exec_count); end
        checks++; if (sel_task !== 4'h0) begin errors++; $display("FAIL reset_sel got %h want 0", sel_task); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_host_latency();
        cmd_valid = 1'b1; cmd_data = 12'h215;
        tick();
        cmd_valid = 1'b0;
        checks++; if (op_word !== 16'h0000) begin errors++; $display("FAIL lat_t1 got %h want 0000", op_word); end
        tick();
        checks++; if (op_word !== 16'h0215) begin errors++; $display("FAIL lat_t2 got %h want 0215", op_word); end
        for (int i = 1; i < HC; i++) begin
            tick();
            checks++; if (op_word !== 16'h0215) begin errors++; $display("FAIL lat_hold%0d got %h want 0215", i, op_word); end
        end
        for (int i = 0; i < GC; i++) begin
            tick();
            checks++; if (op_word !== 16'h0000 || busy !== 1'b1) begin errors++; $display("FAIL lat_gap%0d got op=%h busy=%b want op=0000 busy=1", i, op_word, busy); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_idle got busy=%b want 0", busy); end
        checks++; if (exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL lat_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_auto_dispatch();
        bit ok;
        int s0;
        s0 = mon_start.size();
        task_status = {8'h71, 8'h73, 8'h52, 8'h00};
        auto_en = 1'b1;
        wait_op(QT + 8, ok);
        checks++; if (!ok || op_word !== 16'h0370) begin errors++; $display("FAIL auto_op got %h want 0370", op_word); end
        checks++; if (sel_task !== 4'h3) begin errors++; $display("FAIL auto_sel got %h want 3", sel_task); end
        exp_exec++;
        checks++; if (exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL auto_exec got %0d want %0d", exec_count, exp_exec); end
        wait_idle(20, ok);
        wait_op(QT + 8, ok);
        tick();
        auto_en = 1'b0;
        if (ok) exp_exec++;
        checks++;
        if (!ok || mon_start.size() < s0 + 2 || mon_start[s0+1] - mon_start[s0] != QT) begin
            errors++;
            $display("FAIL auto_spacing got %0d want %0d", (mon_start.size() >= s0 + 2) ? mon_start[s0+1] - mon_start[s0] : -1, QT);
        end
        wait_idle(20, ok);
        checks++; if (!ok || exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL auto_exec2 got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_tie();
        bit ok;
        task_status = {8'h00, 8'h44, 8'h00, 8'h44};
        auto_en = 1'b1;
        wait_op(QT + 8, ok);
        auto_en = 1'b0;
        if (ok) exp_exec++;
        checks++; if (!ok || op_word !== 16'h0470) begin errors++; $display("FAIL tie_op got %h want 0470", op_word); end
        checks++; if (sel_task !== 4'h4) begin errors++; $display("FAIL tie_sel got %h want 4", sel_task); end
        task_status = {8'h00, 8'h00, 8'hF9, 8'h00};
        tick();
        checks++; if (op_word !== 16'h0470) begin errors++; $display("FAIL tie_hold_ignore got %h want 0470", op_word); end
        wait_idle(20, ok);
        checks++; if (!ok || exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL tie_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_random_arb();
        bit ok;
        bit any;
        logic [3:0] eid;
        logic [15:0] eop;
        logic [8*NT-1:0] st;
        for (int it = 0; it < 10; it++) begin
            wait_idle(40, ok);
            st = (it == 0) ? '0 : rand_status();
            task_status = st;
            any = arb_model(st, eid);
            eop = {4'h0, eid, 4'h7, 4'h0};
            auto_en = 1'b1;
            wait_op(QT + 4, ok);
            auto_en = 1'b0;
            checks++;
            if (any) begin
                if (ok) exp_exec++;
                if (!ok || op_word !== eop || sel_task !== eid) begin
                    errors++;
                    $display("FAIL rand_arb%0d status=%h got op=%h sel=%h want op=%h sel=%h", it, st, op_word, sel_task, eop, eid);
                end
            end else if (ok) begin
                errors++;
                $display("FAIL rand_arb%0d status=%h got op=%h want no dispatch", it, st, op_word);
            end
        end
        wait_idle(40, ok);
        checks++; if (!ok || exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL rand_arb_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic check_trace(input string tag, input int s0, input logic [11:0] exp_q[$]);
        int n;
        n = 0;
        while (mon_w.size() < s0 + exp_q.size() && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (mon_w.size() < s0 + exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", tag, mon_w.size() - s0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (mon_w[s0+i] !== {4'h0, exp_q[i]} || mon_len[s0+i] != HC || mon_gap[s0+i] < GC) begin
                    errors++;
                    $display("FAIL %s_op%0d got %h len=%0d gap=%0d want %h len=%0d gap>=%0d", tag, i,
                             mon_w[s0+i], mon_len[s0+i], mon_gap[s0+i], {4'h0, exp_q[i]}, HC, GC);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s0;
        logic [11:0] exp_q[$];
        wait_idle(40, ok);
        s0 = mon_start.size();
        for (int k = 0; k < 6; k++) exp_q.push_back(rand_cmd(1'b0));
        for (int k = 0; k < 6; k++) begin
            push_cmd(exp_q[k], ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_push%0d got ready=0 want 1", k); end
            if (exp_q[k][7:4] == 4'h7) exp_exec++;
            if (k == 4) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got ready=%b want 0", cmd_ready); end
            end
        end
        check_trace("b2b", s0, exp_q);
        wait_idle(40, ok);
        checks++; if (!ok || exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL b2b_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_host_priority();
        bit ok;
        bit any;
        int n;
        logic [3:0] eid;
        logic [15:0] eop;
        logic [11:0] h;
        logic [8*NT-1:0] st;
        wait_idle(40, ok);
        st = rand_status();
        st[7:0] = 8'h31;
        task_status = st;
        any = arb_model(st, eid);
        eop = {4'h0, eid, 4'h7, 4'h0};
        h = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 6)), 4'($urandom_range(0, 15))};
        repeat (QT + 2) tick();
        cmd_valid = 1'b1; cmd_data = h;
        tick();
        cmd_valid = 1'b0; auto_en = 1'b1;
        tick();
        checks++; if (op_word !== {4'h0, h}) begin errors++; $display("FAIL prio_host got %h want %h", op_word, {4'h0, h}); end
        n = 0;
        while (op_word !== eop && n < 30) begin
            tick();
            n++;
        end
        auto_en = 1'b0;
        if (any && op_word === eop) exp_exec++;
        checks++; if (op_word !== eop || n != HC + GC + 1) begin errors++; $display("FAIL prio_auto got op=%h after %0d want op=%h after %0d", op_word, n, eop, HC + GC + 1); end
        wait_idle(40, ok);
        checks++; if (!ok || exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL prio_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_random_cmds();
        bit ok;
        int s0;
        logic [11:0] c;
        logic [11:0] exp_q[$];
        wait_idle(40, ok);
        s0 = mon_start.size();
        for (int k = 0; k < 16; k++) begin
            c = rand_cmd(1'b1);
            if (c[7:4] != 4'h0) exp_q.push_back(c);
            if (c[7:4] == 4'h7) exp_exec++;
            push_cmd(c, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd_push%0d got ready=0 want 1", k); end
            repeat ($urandom_range(0, 6)) tick();
        end
        check_trace("rnd", s0, exp_q);
        wait_idle(40, ok);
        checks++; if (mon_start.size() != s0 + exp_q.size()) begin errors++; $display("FAIL rnd_extra got %0d ops want %0d", mon_start.size() - s0, exp_q.size()); end
        checks++; if (exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL rnd_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit saw;
        int s0;
        logic [11:0] c0;
        wait_idle(40, ok);
        c0 = {4'($urandom_range(1, 15)), 4'h7, 4'($urandom_range(0, 15))};
        push_cmd(c0, ok);
        push_cmd(rand_cmd(1'b0), ok);
        push_cmd(rand_cmd(1'b0), ok);
        checks++; if (op_word !== {4'h0, c0} || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got op=%h busy=%b want op=%h busy=1", op_word, busy, {4'h0, c0}); end
        #3;
        rst = 1'b1;
        #1;
        exp_exec = 0;
        checks++; if (op_word !== 16'h0000) begin errors++; $display("FAIL rst_op got %h want 0000", op_word); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_flags got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready); end
        checks++; if (exec_count !== 16'h0000 || sel_task !== 4'h0) begin errors++; $display("FAIL rst_regs got exec=%0d sel=%h want 0 0", exec_count, sel_task); end
        tick();
        rst = 1'b0;
        tick();
        s0 = mon_start.size();
        repeat (12) tick();
        checks++; if (mon_start.size() != s0) begin errors++; $display("FAIL rst_discard got %0d ops want 0", mon_start.size() - s0); end
        push_cmd(12'h200, ok);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy || op_word != 16'h0000) saw = 1'b1;
            tick();
        end
        checks++; if (saw || !ok) begin errors++; $display("FAIL rst_nop got busy_seen=%b accepted=%b want busy_seen=0 accepted=1", saw, ok); end
        checks++; if (exec_count !== 16'(exp_exec)) begin errors++; $display("FAIL rst_exec got %0d want %0d", exec_count, exp_exec); end
    endtask

    initial begin
        test_reset();
        test_host_latency();
        test_auto_dispatch();
        test_tie();
        test_random_arb();
        test_back_to_back();
        test_host_priority();
        test_random_cmds();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
